// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter sharing one DDR3 read port among NUM_REQ clients,
// one read outstanding at a time, with a watchdog that aborts unacknowledged reads.
module mem_read_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic                     clock,
  input  logic                     reset_l,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0][28:0] req_addr,
  output logic [NUM_REQ-1:0]       rd_valid,
  output logic [NUM_REQ-1:0]       rd_err,
  output logic [63:0]              rd_data,
  output logic                     timeout_flag,
  input  logic                     timeout_clr,
  output logic [28:0]              mem_addr,
  output logic                     mem_read_en,
  input  logic [63:0]              mem_data,
  input  logic                     mem_ack
);

  localparam int              OW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [15:0]     CNT_LAST  = 16'(TIMEOUT - 1);
  localparam logic [OW-1:0]   LAST_INIT = OW'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP, DROP} state_t;

  state_t            state_q, state_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic [OW-1:0]     last_grant_q, last_grant_d;
  logic [28:0]       mem_addr_q, mem_addr_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [63:0]       rd_data_q, rd_data_d;
  logic              flag_q, flag_d;

  logic              grant_found;
  logic [OW-1:0]     grant_idx;
  logic [OW-1:0]     cand;
  logic [NUM_REQ-1:0] owner_oh;

  // Search starts one past the last grant so a busy client cannot starve the others.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = OW'((32'(last_grant_q) + i + 32'd1) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    mem_addr_d   = mem_addr_q;
    cnt_d        = cnt_q;
    rd_data_d    = rd_data_q;
    flag_d       = flag_q;
    mem_read_en  = 1'b0;
    rd_valid     = '0;
    rd_err       = '0;

    if (timeout_clr) flag_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grant_found) begin
          owner_d      = grant_idx;
          last_grant_d = grant_idx;
          mem_addr_d   = req_addr[grant_idx];
          cnt_d        = '0;
          state_d      = BUSY;
        end
      end
      BUSY: begin
        mem_read_en = 1'b1;
        // An ack arriving on the final watchdog cycle still completes the read.
        if (mem_ack) begin
          rd_data_d = mem_data;
          state_d   = RESP;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          state_d = DROP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RESP: begin
        rd_valid = owner_oh;
        state_d  = IDLE;
      end
      DROP: begin
        rd_err  = owner_oh;
        flag_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_grant_q <= LAST_INIT;
      mem_addr_q   <= '0;
      cnt_q        <= '0;
      rd_data_q    <= '0;
      flag_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      mem_addr_q   <= mem_addr_d;
      cnt_q        <= cnt_d;
      rd_data_q    <= rd_data_d;
      flag_q       <= flag_d;
    end
  end

  assign mem_addr     = mem_addr_q;
  assign rd_data      = rd_data_q;
  assign timeout_flag = flag_q;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Bench for mem_read_arbiter: directed transaction table, corner sequences,
// then randomized traffic against a transaction-level reference model.
module tb_mem_read_arbiter;

  localparam int N  = 3;
  localparam int TO = 8;

  logic                clock = 1'b0;
  logic                reset_l;
  logic [N-1:0]        req_valid;
  logic [N-1:0][28:0]  req_addr;
  logic [N-1:0]        rd_valid;
  logic [N-1:0]        rd_err;
  logic [63:0]         rd_data;
  logic                timeout_flag;
  logic                timeout_clr;
  logic [28:0]         mem_addr;
  logic                mem_read_en;
  logic [63:0]         mem_data;
  logic                mem_ack;

  mem_read_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clock        (clock),
    .reset_l      (reset_l),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .rd_valid     (rd_valid),
    .rd_err       (rd_err),
    .rd_data      (rd_data),
    .timeout_flag (timeout_flag),
    .timeout_clr  (timeout_clr),
    .mem_addr     (mem_addr),
    .mem_read_en  (mem_read_en),
    .mem_data     (mem_data),
    .mem_ack      (mem_ack)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] oh(input int c);
    if (c < 0) return '0;
    return N'(1) << c;
  endfunction

  typedef struct {
    logic [N-1:0] req;
    int           ack_at;     // BUSY cycle (1-based) carrying mem_ack; 0 = never
    logic [63:0]  data;
    int           exp_owner;
    logic         exp_err;
    int           exp_busy;   // cycles mem_read_en is high
    int           exp_wait;   // negedges from request drive to mem_read_en
  } vec_t;

  vec_t        vt[12];
  logic [28:0] addr_tab[N];

  // Reference model: one outstanding transaction plus a one-cycle report slot.
  int          m_inflight, m_age, m_done, m_last;
  logic        m_err, m_flag;
  logic [28:0] m_addr;
  logic [63:0] m_data;

  task automatic model_reset();
    m_inflight = -1; m_age = 0; m_done = -1; m_err = 1'b0;
    m_last = N - 1; m_flag = 1'b0; m_addr = '0; m_data = '0;
  endtask

  task automatic model_edge();
    logic nf;
    int   best, bestd, d;
    nf = m_flag;
    if (timeout_clr) nf = 1'b0;
    if (m_done >= 0 && m_err) nf = 1'b1;
    if (m_inflight >= 0) begin
      if (mem_ack) begin
        m_data = mem_data; m_done = m_inflight; m_err = 1'b0; m_inflight = -1;
      end else if (m_age == TO - 1) begin
        m_done = m_inflight; m_err = 1'b1; m_inflight = -1;
      end else begin
        m_age++;
      end
    end else if (m_done >= 0) begin
      m_done = -1;
    end else begin
      // Winner is the requester at the smallest rotational distance past the last grant.
      best = -1; bestd = N;
      for (int c = 0; c < N; c++) begin
        d = (c - m_last - 1 + 2 * N) % N;
        if (req_valid[c] && d < bestd) begin bestd = d; best = c; end
      end
      if (best >= 0) begin
        m_inflight = best; m_age = 0; m_last = best; m_addr = req_addr[best];
      end
    end
    m_flag = nf;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int          w, busy, seen;
    logic [63:0] last_data;

    addr_tab[0] = 29'h0000123;
    addr_tab[1] = 29'h0ABCDE0;
    addr_tab[2] = 29'h1555555;

    vt[0]  = '{3'b001, 4, 64'hDEADBEEF_CAFEF00D, 0, 1'b0, 4, 1};
    vt[1]  = '{3'b011, 2, 64'h1111_2222_3333_4444, 1, 1'b0, 2, 2};
    vt[2]  = '{3'b011, 2, 64'h5555_6666_7777_8888, 0, 1'b0, 2, 2};
    vt[3]  = '{3'b011, 2, 64'h0123_4567_89AB_CDEF, 1, 1'b0, 2, 2};
    vt[4]  = '{3'b011, 2, 64'hFEDC_BA98_7654_3210, 0, 1'b0, 2, 2};
    vt[5]  = '{3'b011, 0, 64'h0,                   1, 1'b1, 8, 2};
    vt[6]  = '{3'b011, 2, 64'hA5A5_A5A5_5A5A_5A5A, 0, 1'b0, 2, 2};
    vt[7]  = '{3'b011, 8, 64'hC0FF_EE00_BADC_0DE5, 1, 1'b0, 8, 2};
    vt[8]  = '{3'b111, 1, 64'h0000_0000_0000_0001, 2, 1'b0, 1, 2};
    vt[9]  = '{3'b111, 3, 64'h8000_0000_0000_0000, 0, 1'b0, 3, 2};
    vt[10] = '{3'b110, 0, 64'h0,                   1, 1'b1, 8, 2};
    vt[11] = '{3'b100, 5, 64'h1357_9BDF_2468_ACE0, 2, 1'b0, 5, 2};

    reset_l = 1'b0; req_valid = '0; timeout_clr = 1'b0; mem_ack = 1'b0; mem_data = '0;
    for (int i = 0; i < N; i++) req_addr[i] = addr_tab[i];
    last_data = '0;
    @(negedge clock);
    chk("reset_en",    64'(mem_read_en),  64'(0));
    chk("reset_addr",  64'(mem_addr),     64'(0));
    chk("reset_data",  rd_data,           64'(0));
    chk("reset_pulse", 64'(rd_valid | rd_err), 64'(0));
    chk("reset_flag",  64'(timeout_flag), 64'(0));
    @(negedge clock);
    reset_l = 1'b1;
    @(negedge clock);

    for (int r = 0; r < 12; r++) begin
      req_valid = vt[r].req;
      w = 0;
      while (w < 12) begin
        @(negedge clock); w++;
        if (mem_read_en) break;
      end
      chk("grant_wait", 64'(w), 64'(vt[r].exp_wait));
      chk("mem_addr", 64'(mem_addr), 64'(addr_tab[vt[r].exp_owner]));
      busy = 0;
      while (mem_read_en && busy < 20) begin
        busy++;
        mem_ack  = (busy == vt[r].ack_at);
        mem_data = vt[r].data;
        @(negedge clock);
        if (mem_read_en) chk("addr_hold", 64'(mem_addr), 64'(addr_tab[vt[r].exp_owner]));
      end
      mem_ack = 1'b0;
      chk("busy_len", 64'(busy), 64'(vt[r].exp_busy));
      chk("rd_valid", 64'(rd_valid), 64'(vt[r].exp_err ? '0 : oh(vt[r].exp_owner)));
      chk("rd_err",   64'(rd_err),   64'(vt[r].exp_err ? oh(vt[r].exp_owner) : '0));
      if (!vt[r].exp_err) begin
        chk("rd_data", rd_data, vt[r].data);
        last_data = vt[r].data;
      end
    end
    req_valid = '0;
    chk("flag_after_timeouts", 64'(timeout_flag), 64'(1));

    // Stale ack in IDLE must not disturb rd_data or pulse anything.
    @(negedge clock);
    mem_ack = 1'b1; mem_data = 64'hBAD0_BAD0_BAD0_BAD0;
    @(negedge clock);
    mem_ack = 1'b0;
    chk("stale_data",  rd_data, last_data);
    chk("stale_pulse", 64'(rd_valid | rd_err), 64'(0));
    chk("stale_en",    64'(mem_read_en), 64'(0));

    timeout_clr = 1'b1;
    @(negedge clock);
    timeout_clr = 1'b0;
    chk("clr_alone", 64'(timeout_flag), 64'(0));

    // Clear coinciding with a timeout report: the set must win.
    req_valid = 3'b001;
    w = 0;
    while (w < 12) begin
      @(negedge clock); w++;
      if (mem_read_en) break;
    end
    busy = 0;
    while (mem_read_en && busy < 20) begin
      @(negedge clock); busy++;
    end
    chk("drop_rd_err", 64'(rd_err), 64'(3'b001));
    chk("drop_flag_before", 64'(timeout_flag), 64'(0));
    timeout_clr = 1'b1;
    req_valid   = '0;
    @(negedge clock);
    timeout_clr = 1'b0;
    chk("clr_vs_set", 64'(timeout_flag), 64'(1));

    // Reset while BUSY on client 1; afterwards client 0 must win first.
    req_valid = 3'b011;
    w = 0;
    while (w < 12) begin
      @(negedge clock); w++;
      if (mem_read_en) break;
    end
    chk("pre_reset_addr", 64'(mem_addr), 64'(addr_tab[1]));
    @(negedge clock);
    @(negedge clock);
    #2;
    reset_l = 1'b0;
    #1;
    chk("async_en",   64'(mem_read_en),  64'(0));
    chk("async_flag", 64'(timeout_flag), 64'(0));
    chk("async_addr", 64'(mem_addr),     64'(0));
    @(negedge clock);
    @(negedge clock);
    reset_l = 1'b1;
    w = 0; seen = 0;
    while (w < 12) begin
      @(negedge clock); w++;
      if (|(rd_valid | rd_err)) seen++;
      if (mem_read_en) break;
    end
    chk("post_reset_wait",  64'(w), 64'(1));
    chk("post_reset_pulse", 64'(seen), 64'(0));
    chk("post_reset_addr",  64'(mem_addr), 64'(addr_tab[0]));
    mem_ack = 1'b1; mem_data = 64'h0F0F_0F0F_F0F0_F0F0;
    @(negedge clock);
    mem_ack = 1'b0; req_valid = '0;
    chk("post_reset_valid", 64'(rd_valid), 64'(3'b001));
    chk("post_reset_data",  rd_data, 64'h0F0F_0F0F_F0F0_F0F0);

    // Randomized traffic against the reference model.
    reset_l = 1'b0; req_valid = '0; mem_ack = 1'b0; timeout_clr = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_l = 1'b1;
    model_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      chk("r_en",    64'(mem_read_en), 64'(m_inflight >= 0));
      chk("r_addr",  64'(mem_addr), 64'(m_addr));
      chk("r_valid", 64'(rd_valid), 64'((m_done >= 0 && !m_err) ? oh(m_done) : '0));
      chk("r_err",   64'(rd_err),   64'((m_done >= 0 &&  m_err) ? oh(m_done) : '0));
      chk("r_data",  rd_data, m_data);
      chk("r_flag",  64'(timeout_flag), 64'(m_flag));
      chk("r_one_pulse", 64'($countones(rd_valid | rd_err) <= 1), 64'(1));

      for (int i = 0; i < N; i++) begin
        if (req_valid[i]) begin
          if (m_done == i) req_valid[i] = 1'b0;
        end else if ($urandom_range(3) == 0) begin
          req_valid[i] = 1'b1;
          req_addr[i]  = 29'($urandom);
        end
      end
      mem_ack     = (m_inflight >= 0) ? ($urandom_range(4) == 0) : ($urandom_range(9) == 0);
      mem_data    = {$urandom, $urandom};
      timeout_clr = ($urandom_range(9) == 0);
      model_edge();
      @(negedge clock);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
